// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer slice.
//   state_t              : sequencer state encodings (BOOT/RUN/HOLD)
//   INSTR_BYTES          : PC increment per instruction
//   DEFAULT_RESET_VECTOR : PC used after reset unless overridden
//   word_align()         : clears the byte-offset bits of an address
`ifndef FETCH_PC_SEQUENCER_PKG_SV
`define FETCH_PC_SEQUENCER_PKG_SV
package fetch_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] INSTR_BYTES          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage
`endif

// File: rtl/fetch_tag_pipe.sv
// Depth-DEPTH shift register of {pc, ok} tags that tracks in-flight fetches.
// The tail entry lines up with the word currently returning from the fetch
// unit.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : synchronous clear of every ok bit (the new entry included)
//   i_pc, i_ok   : tag entering entry 0 this cycle
//   o_tail_pc/ok : oldest entry
module fetch_tag_pipe
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic        i_ok,
  output logic [31:0] o_tail_pc,
  output logic        o_tail_ok
);

  logic [DEPTH-1:0][31:0] r_pc;
  logic [DEPTH-1:0]       r_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= '0;
      r_ok <= '0;
    end else begin
      r_pc[0] <= i_pc;
      r_ok[0] <= i_ok && !i_clear;
      for (int i = 1; i < DEPTH; i++) begin
        r_pc[i] <= r_pc[i-1];
        r_ok[i] <= r_ok[i-1] && !i_clear;
      end
    end
  end

  assign o_tail_pc = r_pc[DEPTH-1];
  assign o_tail_ok = r_ok[DEPTH-1];

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Program-counter stage feeding instruction_fetch_unit. Issues a PC every
// cycle, pairs each returning word with its PC via a tag pipe matched to
// the fetch latency, and presents {if_pc, if_instruction, if_valid} to the
// IF/ID register. Stall rewinds to the oldest owed PC and replays; redirect
// squashes everything in flight.
//   system_clock, reset      : clock, asynchronous active-high reset
//   stall                    : downstream hold request
//   redirect_valid/target    : taken branch/jump from EX
//   fetch_valid/instruction_in : returning word from the fetch unit
//   program_counter          : PC to the fetch unit
//   if_pc/if_instruction/if_valid : aligned output to IF/ID
//   misaligned_fault         : sticky, a redirect target had low bits set
//   replay_count             : saturating count of stall rewinds
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = DEFAULT_RESET_VECTOR,
  parameter int          FETCH_LATENCY = 2
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        fetch_valid,
  input  logic [31:0] instruction_in,
  output logic [31:0] program_counter,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        misaligned_fault,
  output logic [15:0] replay_count
);

  logic [31:0] r_pc, r_next_exp, r_if_pc, r_if_instr;
  logic        r_if_valid, r_fault;
  logic [15:0] r_replay;
  state_t      r_state;

  logic [31:0] w_pc_nxt, w_next_exp_nxt, w_if_pc_nxt, w_if_instr_nxt;
  logic        w_if_valid_nxt, w_fault_nxt;
  logic [15:0] w_replay_nxt;
  state_t      w_state_nxt;

  logic        w_issue_ok, w_accept, w_tail_ok;
  logic [31:0] w_tail_pc, w_target;

  assign w_issue_ok = !stall && !redirect_valid;
  assign w_target   = word_align(redirect_target);
  assign w_accept   = w_tail_ok && fetch_valid && w_issue_ok &&
                      (w_tail_pc == r_next_exp);

  // Any issue that is not ok (stall/redirect) also invalidates every
  // outstanding tag, so clearing on the same condition is sufficient.
  fetch_tag_pipe #(.DEPTH(FETCH_LATENCY)) u_tag_pipe (
    .i_clk     (system_clock),
    .i_rst     (reset),
    .i_clear   (!w_issue_ok),
    .i_pc      (r_pc),
    .i_ok      (w_issue_ok),
    .o_tail_pc (w_tail_pc),
    .o_tail_ok (w_tail_ok)
  );

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_next_exp <= RESET_VECTOR;
      r_if_pc    <= '0;
      r_if_instr <= '0;
      r_if_valid <= 1'b0;
      r_fault    <= 1'b0;
      r_replay   <= '0;
      r_state    <= BOOT;
    end else begin
      r_pc       <= w_pc_nxt;
      r_next_exp <= w_next_exp_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_fault    <= w_fault_nxt;
      r_replay   <= w_replay_nxt;
      r_state    <= w_state_nxt;
    end
  end

  always_comb begin
    w_pc_nxt       = r_pc;
    w_next_exp_nxt = r_next_exp;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_valid_nxt = r_if_valid;
    w_fault_nxt    = r_fault;
    w_replay_nxt   = r_replay;
    w_state_nxt    = r_state;
    if (redirect_valid) begin
      // Redirect beats stall: the squash must happen even while held.
      w_pc_nxt       = w_target;
      w_next_exp_nxt = w_target;
      w_if_valid_nxt = 1'b0;
      w_state_nxt    = RUN;
      if (redirect_target[1:0] != 2'b00) w_fault_nxt = 1'b1;
    end else if (stall) begin
      // Rewind to the oldest owed PC; everything in flight is replayed.
      w_pc_nxt = r_next_exp;
      if (r_state != HOLD) begin
        w_state_nxt = HOLD;
        if (r_replay != 16'hFFFF) w_replay_nxt = r_replay + 16'd1;
      end
    end else begin
      w_pc_nxt       = r_pc + INSTR_BYTES;
      w_if_valid_nxt = w_accept;
      if (w_accept) begin
        w_if_pc_nxt    = w_tail_pc;
        w_if_instr_nxt = instruction_in;
        w_next_exp_nxt = r_next_exp + INSTR_BYTES;
      end
      case (r_state)
        HOLD:    w_state_nxt = RUN;
        BOOT:    if (fetch_valid) w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // An ok tag that would otherwise be accepted must always match the PC
  // owed downstream; a mismatch means the issue/rewind bookkeeping is broken.
  a_tag_in_order: assert property (@(posedge system_clock) disable iff (reset)
    !(w_tail_ok && fetch_valid && w_issue_ok && (w_tail_pc != r_next_exp)));

  assign program_counter  = r_pc;
  assign if_pc            = r_if_pc;
  assign if_instruction   = r_if_instr;
  assign if_valid         = r_if_valid;
  assign misaligned_fault = r_fault;
  assign replay_count     = r_replay;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_valid;
  logic [31:0] instruction_in;
  logic [31:0] program_counter, if_pc, if_instruction;
  logic        if_valid, misaligned_fault;
  logic [15:0] replay_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .system_clock    (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_valid     (fetch_valid),
    .instruction_in  (instruction_in),
    .program_counter (program_counter),
    .if_pc           (if_pc),
    .if_instruction  (if_instruction),
    .if_valid        (if_valid),
    .misaligned_fault(misaligned_fault),
    .replay_count    (replay_count)
  );

  // Fetch unit model: 2-cycle latency, memory word == address.
  logic [31:0] fp0, fp1;
  logic        fv0, fv1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fp0 <= '0; fp1 <= '0; fv0 <= 1'b0; fv1 <= 1'b0;
    end else begin
      fp0 <= program_counter; fv0 <= 1'b1;
      fp1 <= fp0;             fv1 <= fv0;
    end
  end
  assign instruction_in = fp1;
  assign fetch_valid    = fv1;

  // Leaves the bench at the negedge of cycle 0 after release.
  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (program_counter !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=0", program_counter); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    n_vec++; if (if_pc !== 32'h0 || if_instruction !== 32'h0) begin n_err++; $display("FAIL rst_if got=%h/%h exp=0/0", if_pc, if_instruction); end
    n_vec++; if (misaligned_fault !== 1'b0 || replay_count !== 16'h0) begin n_err++; $display("FAIL rst_stat got=%b/%h exp=0/0", misaligned_fault, replay_count); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      n_vec++;
      if (program_counter !== 32'(4*c)) begin n_err++; $display("FAIL stream_pcq cyc=%0d got=%h exp=%h", c, program_counter, 32'(4*c)); end
      n_vec++;
      if (if_valid !== (c >= 3)) begin n_err++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, if_valid, c >= 3); end
      if (c >= 3) begin
        n_vec++;
        if (if_pc !== 32'(4*(c-3)) || if_instruction !== 32'(4*(c-3))) begin
          n_err++; $display("FAIL stream_if cyc=%0d got=%h/%h exp=%h", c, if_pc, if_instruction, 32'(4*(c-3)));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic        ev;
    logic [31:0] epc, epcq;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      ev   = (c >= 3 && c <= 10) || c >= 14;
      epc  = (c >= 14) ? 32'(32'h100 + 4*(c-14)) : 32'(4*(c-3));
      epcq = (c >= 11) ? 32'(32'h100 + 4*(c-11)) : 32'(4*c);
      n_vec++;
      if (program_counter !== epcq) begin n_err++; $display("FAIL redir_pcq cyc=%0d got=%h exp=%h", c, program_counter, epcq); end
      n_vec++;
      if (if_valid !== ev) begin n_err++; $display("FAIL redir_valid cyc=%0d got=%b exp=%b", c, if_valid, ev); end
      if (ev) begin
        n_vec++;
        if (if_pc !== epc || if_instruction !== epc) begin n_err++; $display("FAIL redir_if cyc=%0d got=%h/%h exp=%h", c, if_pc, if_instruction, epc); end
      end
      redirect_valid  = (c == 10);
      redirect_target = 32'h0000_0100;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  // Three-cycle stall at 8..10, then a one-cycle stall at 20.
  task automatic test_stall();
    logic        ev;
    logic [31:0] epc, epcq;
    logic [15:0] erc;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      ev = (c >= 3 && c <= 11) || (c >= 14 && c <= 21) || c >= 24;
      if (c <= 8)       epc = 32'(4*(c-3));
      else if (c <= 11) epc = 32'h14;
      else if (c <= 20) epc = 32'(32'h18 + 4*(c-14));
      else if (c <= 23) epc = 32'h30;
      else              epc = 32'(32'h34 + 4*(c-24));
      if (c <= 8)       epcq = 32'(4*c);
      else if (c <= 11) epcq = 32'h18;
      else if (c <= 20) epcq = 32'(32'h18 + 4*(c-11));
      else              epcq = 32'(32'h34 + 4*(c-21));
      erc = (c <= 8) ? 16'd0 : (c <= 20) ? 16'd1 : 16'd2;
      n_vec++;
      if (program_counter !== epcq) begin n_err++; $display("FAIL stall_pcq cyc=%0d got=%h exp=%h", c, program_counter, epcq); end
      n_vec++;
      if (if_valid !== ev) begin n_err++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", c, if_valid, ev); end
      if (ev) begin
        n_vec++;
        if (if_pc !== epc || if_instruction !== epc) begin n_err++; $display("FAIL stall_if cyc=%0d got=%h/%h exp=%h", c, if_pc, if_instruction, epc); end
      end
      n_vec++;
      if (replay_count !== erc) begin n_err++; $display("FAIL stall_replay cyc=%0d got=%0d exp=%0d", c, replay_count, erc); end
      stall = (c >= 8 && c <= 10) || c == 20;
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  task automatic test_stall_redirect();
    logic        ev;
    logic [31:0] epc, epcq;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      ev   = (c >= 3 && c <= 9) || c >= 13;
      epc  = (c >= 13) ? 32'(32'h40 + 4*(c-13)) : 32'(4*(c-3));
      epcq = (c >= 10) ? 32'(32'h40 + 4*(c-10)) : 32'(4*c);
      n_vec++;
      if (program_counter !== epcq) begin n_err++; $display("FAIL sr_pcq cyc=%0d got=%h exp=%h", c, program_counter, epcq); end
      n_vec++;
      if (if_valid !== ev) begin n_err++; $display("FAIL sr_valid cyc=%0d got=%b exp=%b", c, if_valid, ev); end
      if (ev) begin
        n_vec++;
        if (if_pc !== epc) begin n_err++; $display("FAIL sr_if cyc=%0d got=%h exp=%h", c, if_pc, epc); end
      end
      n_vec++;
      if (replay_count !== 16'd0) begin n_err++; $display("FAIL sr_replay cyc=%0d got=%0d exp=0", c, replay_count); end
      stall           = (c == 9);
      redirect_valid  = (c == 9);
      redirect_target = 32'h0000_0040;
      @(negedge clk);
    end
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    logic        ev;
    logic [31:0] epc, epcq;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      ev   = (c >= 3 && c <= 6) || c >= 10;
      epc  = (c >= 10) ? 32'(32'h100 + 4*(c-10)) : 32'(4*(c-3));
      epcq = (c >= 7) ? 32'(32'h100 + 4*(c-7)) : 32'(4*c);
      n_vec++;
      if (misaligned_fault !== (c >= 7)) begin n_err++; $display("FAIL mis_fault cyc=%0d got=%b exp=%b", c, misaligned_fault, c >= 7); end
      n_vec++;
      if (program_counter !== epcq) begin n_err++; $display("FAIL mis_pcq cyc=%0d got=%h exp=%h", c, program_counter, epcq); end
      n_vec++;
      if (if_valid !== ev) begin n_err++; $display("FAIL mis_valid cyc=%0d got=%b exp=%b", c, if_valid, ev); end
      if (ev) begin
        n_vec++;
        if (if_pc !== epc) begin n_err++; $display("FAIL mis_if cyc=%0d got=%h exp=%h", c, if_pc, epc); end
      end
      redirect_valid  = (c == 6);
      redirect_target = 32'h0000_0102;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (6) @(negedge clk);
    n_vec++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC) begin n_err++; $display("FAIL mr_pre got=%b/%h exp=1/0000000c", if_valid, if_pc); end
    // Assert between edges and look before the next rising edge.
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (program_counter !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0) begin
      n_err++; $display("FAIL mr_async got=%h/%b/%h/%h exp=0/0/0/0", program_counter, if_valid, if_pc, if_instruction);
    end
    n_vec++;
    if (replay_count !== 16'h0 || misaligned_fault !== 1'b0) begin n_err++; $display("FAIL mr_stat got=%h/%b exp=0/0", replay_count, misaligned_fault); end
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      n_vec++;
      if (if_valid !== (c >= 3)) begin n_err++; $display("FAIL mr_valid cyc=%0d got=%b exp=%b", c, if_valid, c >= 3); end
      if (c >= 3) begin
        n_vec++;
        if (if_pc !== 32'(4*(c-3)) || if_instruction !== 32'(4*(c-3))) begin
          n_err++; $display("FAIL mr_if cyc=%0d got=%h/%h exp=%h", c, if_pc, if_instruction, 32'(4*(c-3)));
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_misaligned();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Program-counter stage directly upstream of `instruction_fetch_unit`. Generates `program_counter` for the fetch unit every cycle. Tracks in-flight fetches through a tag pipe matched to the fetch latency, and pairs each returning `instruction` with its PC. Presents aligned `{pc, instruction, valid}` to the IF/ID register, handling stall (rewind and replay) and branch/jump redirect (squash).

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, PC after reset; must be word-aligned.
- `FETCH_LATENCY`, 2, cycles from a PC on `program_counter` to its word on `instruction_in`; legal range 1..4.

Ports:
- `system_clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: downstream cannot accept; hold outputs.
- `redirect_valid` in 1: branch/jump taken (from EX).
- `redirect_target` in 32: redirect PC.
- `fetch_valid` in 1: `valid` from fetch unit.
- `instruction_in` in 32: `instruction` from fetch unit.
- `program_counter` out 32: PC to fetch unit.
- `if_pc` out 32: PC of `if_instruction`.
- `if_instruction` out 32: fetched word.
- `if_valid` out 1: `if_*` holds a real instruction.
- `misaligned_fault` out 1: sticky; a redirect had `target[1:0]!=0`.
- `replay_count` out 16: saturating count of stall-induced rewinds.

## Operation
- Registers:
  - `pc_q` drives `program_counter`.
  - `next_expected` is the PC of the next instruction owed downstream.
  - Tag pipe is `FETCH_LATENCY` entries of `{pc, ok}`.
  - Output registers hold `if_*`.
  - 2-bit `state` is one of BOOT, RUN or HOLD.
- Issue: `issue_ok = !stall && !redirect_valid`. Each cycle the tag pipe shifts, and entry 0 takes `{pc_q, issue_ok}`. The tail entry is the arriving tag for `instruction_in`.
- Accept: the tail is accepted when tail.ok, `fetch_valid`, `!stall`, `!redirect_valid`, and tail.pc == `next_expected`. An accept loads `if_pc`/`if_instruction`, sets `if_valid`=1 and sets `next_expected` += 4. A tail.ok entry with a PC mismatch is dropped; this is a verification assertion and must never fire.
- Priority (highest first), per cycle:
  - Redirect:
    - `pc_q` and `next_expected` load `{target[31:2],2'b00}`.
    - All tag ok bits clear and `if_valid` clears.
    - `state` goes to RUN.
    - If `target[1:0]!=0`, `misaligned_fault` sets. The redirect is still taken with the aligned target.
  - Stall:
    - `pc_q` loads `next_expected` (rewind) and all tag ok bits clear.
    - `if_*` hold their values.
    - On entry from RUN or BOOT, `state` goes to HOLD and `replay_count` increments, saturating at 16'hFFFF.
  - Otherwise:
    - `pc_q` += 4 (32-bit wrap; 32'hFFFF_FFFC becomes 0).
    - `if_valid` = accept.
    - HOLD goes to RUN. BOOT goes to RUN on the first `fetch_valid`=1.
- BOOT discards all arrivals while `fetch_valid`=0. This covers the fetch unit's first post-reset cycle.
- Redirect and stall in the same cycle: redirect wins, and `if_valid` drops despite the stall.

## Timing
- Reset values:
  - `program_counter`=`RESET_VECTOR`.
  - `if_pc`=0, `if_instruction`=0, `if_valid`=0.
  - `misaligned_fault`=0, `replay_count`=0.
  - `state`=BOOT; all tag ok bits 0; `next_expected`=`RESET_VECTOR`.
- Assertion mid-operation clears everything immediately (asynchronous).
- PC to `if_valid` latency is `FETCH_LATENCY`+1. With the default:
  - a PC issued in cycle t appears on `if_*` in t+3;
  - after reset release, first `if_valid`=1 is in cycle 3 with `if_pc`=`RESET_VECTOR`, then one instruction per cycle.
- Redirect in cycle t:
  - `program_counter`=target in t+1.
  - `if_valid`=0 in t+1..t+3.
  - Target instruction is on `if_*` in t+4.
- Stall in cycles s..u-1, released in u:
  - `if_*` constant through u.
  - `program_counter`=`next_expected` from s+1.
  - `if_valid`=0 in u+1..u+2, then the replayed instruction in u+3.
  - A one-cycle stall costs `FETCH_LATENCY` bubbles.
- No combinational path from any input to any output.

## Structure
- Shared header `datapath/pipeline_defs.v` holds:
  - state encodings BOOT=2'd0, RUN=2'd1, HOLD=2'd2;
  - `INSTR_BYTES`=4;
  - default `RESET_VECTOR`.
- One sub-module, `fetch_tag_pipe`: a parameterised depth-`FETCH_LATENCY` shift register of `{pc[31:0], ok}`, with synchronous clear-all-ok and asynchronous reset.
- Include guard per codebase practice.

## Test plan
- Reset release, no stall, memory word = address:
  - `if_valid` rises in cycle 3 with `if_pc`=0.
  - Then `if_pc`=4, 8, 12… each cycle, with `if_instruction`==`if_pc`.
- Redirect to 32'h0000_0100 in cycle 10:
  - `program_counter`=0x100 in cycle 11.
  - `if_valid`=0 in cycles 11–13.
  - `if_pc`=0x100 in cycle 14; no pre-redirect PC appears after cycle 10.
- Stall cycles 8–10 with `if_pc`=0x14 held:
  - `if_*` frozen through cycle 11.
  - `if_valid`=0 in cycles 12–13; `if_pc`=0x18 in cycle 14.
  - `replay_count`=1.
- Stall and redirect (target 0x40) both in cycle 9:
  - `if_valid`=0 in cycle 10; `if_pc`=0x40 in cycle 13.
  - `replay_count` unchanged.
- Redirect to 0x0000_0102:
  - `misaligned_fault`=1 from the next cycle and stays 1.
  - `if_pc`=0x100 three cycles after `program_counter`=0x100.
- `reset` asserted mid-stream while `if_valid`=1:
  - All outputs reach reset values before the next clock edge.
  - Restart matches the first scenario.
